memory_burst_ctrl: RTL and testbench

- Upstream access controller for the 8x8 synchronous memory (8 words x 8 bits, 3-bit address).
- Accepts one burst request at a time over a valid/ready handshake and streams write beats into the memory or read beats out of it.
- Drives the memory's addr, data_in and write_enable ports and consumes its data_out.
- Read path has a 2-entry skid buffer, so downstream backpressure never loses data.

---
 rtl/memory_burst_ctrl.sv | 149 ++++++++++++++
 tb/tb_memory_burst_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_burst_ctrl.sv
// memory_burst_ctrl
//   Burst access controller for an 8x8 synchronous memory. It accepts one
//   request at a time over a valid/ready handshake. Write bursts stream
//   beats straight into the memory. Read bursts issue addresses
//   back-to-back, and the returning words pass through a 2-entry skid
//   buffer so that downstream backpressure never drops a word.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_*               burst request (write flag, start address, beats-1)
//   wr_valid/ready/data write beat stream into the controller
//   rd_valid/ready/data read beat stream out of the controller
//   busy                high whenever a burst is in progress
//   mem_*               connection to the memory (registered read data)
module memory_burst_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] addr_hold;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic              inflight;
    logic [DATA_W-1:0] skid [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic              pop;
    logic              push;
    logic              issue;
    logic              last_beat;
    logic [2:0]        occupancy;

    // The memory returns data one cycle after an address is issued, so the
    // in-flight beat already has a reserved slot. We issue only when the
    // buffer plus that reserved slot, less any word leaving this cycle,
    // stays below two entries.
    assign pop       = (count != 2'd0) && rd_ready;
    assign push      = inflight;
    assign occupancy = 3'(count) + 3'(inflight);
    assign issue     = (state == READ) && (occupancy < (3'd2 + 3'(pop)));
    assign last_beat = (beat_cnt == len_q);

    assign req_ready = (state == IDLE);
    assign wr_ready  = (state == WRITE);
    assign busy      = (state != IDLE);
    assign rd_valid  = (count != 2'd0);
    assign rd_data   = skid[rd_ptr];

    // A write beat goes straight to the memory. Reset masks write enable so
    // that a beat presented during a reset cycle is never stored.
    assign mem_write_enable = (state == WRITE) && wr_valid && !reset;
    assign mem_data_in      = (state == WRITE) ? wr_data : '0;

    // The address bus follows cur_addr while streaming. Otherwise it holds
    // the last address it presented.
    assign mem_addr = ((state == WRITE) || issue) ? cur_addr : addr_hold;

    // Controller state, burst bookkeeping and skid buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            addr_hold <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            inflight  <= 1'b0;
            skid[0]   <= '0;
            skid[1]   <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            addr_hold <= mem_addr;
            inflight  <= issue;

            if (push) begin
                skid[wr_ptr] <= mem_data_out;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr <= req_addr;
                        len_q    <= req_len;
                        beat_cnt <= '0;
                        state    <= req_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        cur_addr <= cur_addr + ADDR_W'(1);
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        cur_addr <= cur_addr + ADDR_W'(1);
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (last_beat) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Leave DRAIN once the final word has been handed downstream.
                    if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_burst_ctrl.sv
// tb_memory_burst_ctrl
//   Bench for memory_burst_ctrl. It includes a behavioural 8x8 memory with
//   registered read data and a reference copy of the memory contents.
//   Expected write beats and read words are queued when stimulus is issued
//   and are compared by an independent monitor.
module tb_memory_burst_ctrl;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_data_out;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_beat_t;

    wr_beat_t          exp_wr_q [$];
    logic [DATA_W-1:0] exp_rd_q [$];
    logic [DATA_W-1:0] ref_mem  [8];
    logic [DATA_W-1:0] mem_model [8];
    logic [DATA_W-1:0] wr_buf   [8];
    logic [6:0]        gap_pat = 7'b1011001;
    logic              init_mem;
    logic              hold_pending = 1'b0;
    logic [DATA_W-1:0] hold_data = '0;
    int                tests_run = 0;
    int                tests_failed = 0;

    memory_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_data          (wr_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_data          (rd_data),
        .busy             (busy),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out)
    );

    always #5 clk = ~clk;

    // Synchronous memory: writes on the enabled edge, read data registered.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 8; i++) mem_model[i] <= 8'h50 + 8'(i);
        end else if (mem_write_enable) begin
            mem_model[mem_addr] <= mem_data_in;
        end
        mem_data_out <= mem_model[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    // Monitor: checks every memory write and every read handoff against the
    // queued expectations, and checks that a stalled read word holds still.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_write_enable) begin
                if (exp_wr_q.size() == 0) begin
                    reportTimeout("wr_unexpected_write");
                end else begin
                    wr_beat_t e;
                    e = exp_wr_q.pop_front();
                    checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
                    checkOutput("wr_data", 32'(mem_data_in), 32'(e.data));
                end
            end
            if (hold_pending) begin
                checkOutput("rd_hold_valid", 32'(rd_valid), 32'd1);
                checkOutput("rd_hold_data", 32'(rd_data), 32'(hold_data));
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd_q.size() == 0) begin
                    reportTimeout("rd_unexpected_beat");
                end else begin
                    logic [DATA_W-1:0] d;
                    d = exp_rd_q.pop_front();
                    checkOutput("rd_data", 32'(rd_data), 32'(d));
                end
            end
            hold_pending = rd_valid && !rd_ready;
            hold_data    = rd_data;
        end else begin
            hold_pending = 1'b0;
        end
    end

    // Present one request and return in the first cycle after acceptance.
    task automatic applyStimulus(input logic is_write, input logic [ADDR_W-1:0] addr,
                                 input logic [LEN_W-1:0] len);
        int n = 0;
        req_valid = 1'b1;
        req_write = is_write;
        req_addr  = addr;
        req_len   = len;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) reportTimeout("req_accept");
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // mode 0: continuous wr_valid, 1: fixed gap pattern, 2: random gaps.
    task automatic writeBurst(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                              input int mode);
        int beats = 0;
        int cyc = 0;
        logic v;
        logic [ADDR_W-1:0] a;
        wr_beat_t e;
        applyStimulus(1'b1, addr, len);
        while (beats <= int'(len) && cyc < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = gap_pat[cyc % 7];
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            wr_valid = v;
            wr_data  = v ? wr_buf[beats] : 8'($urandom);
            if (v && wr_ready) begin
                a = addr + 3'(beats);
                e.addr = a;
                e.data = wr_buf[beats];
                exp_wr_q.push_back(e);
                ref_mem[a] = wr_buf[beats];
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        wr_valid = 1'b0;
        if (beats <= int'(len)) reportTimeout("wr_burst");
        checkOutput("wr_req_ready_after", 32'(req_ready), 32'd1);
        checkOutput("wr_busy_after", 32'(busy), 32'd0);
        checkOutput("wr_beats_outstanding", 32'(exp_wr_q.size()), 32'd0);
    endtask

    // mode 0: rd_ready high, 1: five-cycle stall mid-burst, 2: random ready.
    task automatic readBurst(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                             input int mode);
        int pops = 0;
        int cyc = 0;
        int first = 0;
        int stall = 0;
        int n = 0;
        logic rr;
        logic [ADDR_W-1:0] held_addr = '0;
        for (int i = 0; i <= int'(len); i++) exp_rd_q.push_back(ref_mem[addr + 3'(i)]);
        applyStimulus(1'b0, addr, len);
        while (pops <= int'(len) && cyc < 300) begin
            cyc++;
            if (rd_valid && first == 0) first = cyc;
            case (mode)
                0: rr = 1'b1;
                1: begin
                    if (pops >= 2 && stall < 5) begin
                        if (stall == 1) held_addr = mem_addr;
                        if (stall == 4) begin
                            checkOutput("bp_issue_frozen", 32'(mem_addr), 32'(held_addr));
                            checkOutput("bp_valid_held", 32'(rd_valid), 32'd1);
                        end
                        rr = 1'b0;
                        stall++;
                    end else begin
                        rr = 1'b1;
                    end
                end
                default: rr = ($urandom_range(0, 3) != 0);
            endcase
            rd_ready = rr;
            if (rd_valid && rr) pops++;
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        if (pops <= int'(len)) reportTimeout("rd_burst");
        if (mode == 0) checkOutput("rd_first_latency", 32'(first), 32'd3);
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("rd_busy_after_drain", 32'(busy), 32'd0);
        checkOutput("rd_valid_after_drain", 32'(rd_valid), 32'd0);
        checkOutput("rd_words_outstanding", 32'(exp_rd_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'h50 + 8'(i);
        reset     = 1'b1;
        init_mem  = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        init_mem = 1'b0;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_write_enable), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_data_in", 32'(mem_data_in), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic write and read-back
        wr_buf = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00};
        writeBurst(3'd2, 3'd3, 0);
        readBurst(3'd2, 3'd3, 0);

        // Address wrap 7 -> 0
        wr_buf = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        writeBurst(3'd6, 3'd3, 0);
        readBurst(3'd6, 3'd3, 0);

        // Downstream backpressure over a full-depth read
        readBurst(3'd0, 3'd7, 1);

        // Write beats with gaps
        wr_buf = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
        writeBurst(3'd1, 3'd3, 1);

        // Reset during the third beat of an 8-beat write
        applyStimulus(1'b1, 3'd4, 3'd7);
        for (int b = 0; b < 2; b++) begin
            wr_beat_t e;
            wr_valid = 1'b1;
            wr_data  = 8'hB0 + 8'(b);
            e.addr   = 3'd4 + 3'(b);
            e.data   = wr_data;
            exp_wr_q.push_back(e);
            ref_mem[e.addr] = wr_data;
            @(posedge clk); #1;
        end
        wr_data = 8'hB2;
        reset   = 1'b1;
        #1;
        checkOutput("rst_mid_write_we", 32'(mem_write_enable), 32'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        wr_valid = 1'b0;
        checkOutput("rst_mid_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_mid_wr_outstanding", 32'(exp_wr_q.size()), 32'd0);
        readBurst(3'd4, 3'd7, 0);

        // Random mix of bursts
        repeat (24) begin
            logic              dir;
            logic [ADDR_W-1:0] ra;
            logic [LEN_W-1:0]  rl;
            dir = 1'($urandom_range(0, 1));
            ra  = 3'($urandom);
            rl  = 3'($urandom);
            if (dir) begin
                for (int i = 0; i < 8; i++) wr_buf[i] = 8'($urandom);
                writeBurst(ra, rl, 2);
            end else begin
                readBurst(ra, rl, 2);
            end
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
